sparse_acc_sequencer: RTL and testbench



---
 rtl/sparse_acc_sequencer.sv | 116 +++++++++++
 tb/tb_sparse_acc_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sparse_acc_sequencer.sv
// sparse_acc_sequencer: walks a dense polynomial against two sparse positions, feeding
// rotated word pairs to an external xor_adder and accumulating its result word by word.
module sparse_acc_sequencer #(
    parameter int WORD_WIDTH = 32,
    parameter int LOG_WORDS  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    load_valid,
    input  logic [LOG_WORDS-1:0]    load_addr,
    input  logic [WORD_WIDTH-1:0]   load_data,
    input  logic                    pos_valid,
    output logic                    pos_ready,
    input  logic [LOG_WORDS+4:0]    pos_high,
    input  logic [LOG_WORDS+4:0]    pos_low,
    output logic [WORD_WIDTH-1:0]   high_left,
    output logic [WORD_WIDTH-1:0]   high_right,
    output logic [WORD_WIDTH-1:0]   low_left,
    output logic [WORD_WIDTH-1:0]   low_right,
    output logic [WORD_WIDTH-1:0]   acc_word,
    output logic [4:0]              high_start,
    output logic [4:0]              low_start,
    input  logic [WORD_WIDTH-1:0]   xor_result,
    input  logic [LOG_WORDS-1:0]    rd_addr,
    output logic [WORD_WIDTH-1:0]   rd_data,
    output logic                    busy,
    output logic                    done
);
    localparam int N_WORDS = 1 << LOG_WORDS;
    localparam int PW = LOG_WORDS + 5;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                r_state, w_next;
    logic [WORD_WIDTH-1:0] r_dense [N_WORDS];
    logic [WORD_WIDTH-1:0] r_acc [N_WORDS];
    logic [LOG_WORDS-1:0]  r_i;
    logic [PW-1:0]         r_high, r_low;
    logic [PW-1:0]         w_sh, w_sl;
    logic [LOG_WORDS-1:0]  w_wh, w_wl, w_wh1, w_wl1;
    logic                  w_accept;

    // s = 32*i - p wraps modulo N for free in PW bits
    assign w_sh  = {r_i, 5'd0} - r_high;
    assign w_sl  = {r_i, 5'd0} - r_low;
    assign w_wh  = w_sh[PW-1:5];
    assign w_wl  = w_sl[PW-1:5];
    assign w_wh1 = w_wh + 1'b1;
    assign w_wl1 = w_wl + 1'b1;

    assign high_right = r_dense[w_wh];
    assign high_left  = r_dense[w_wh1];
    assign low_right  = r_dense[w_wl];
    assign low_left   = r_dense[w_wl1];
    assign high_start = w_sh[4:0];
    assign low_start  = w_sl[4:0];
    assign acc_word   = r_acc[r_i];
    assign rd_data    = r_acc[rd_addr];
    assign w_accept   = pos_valid & pos_ready & ~clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        pos_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        if (r_state == IDLE) begin
            pos_ready = 1'b1;
            if (pos_valid) w_next = RUN;
        end else if (r_state == RUN) begin
            busy = 1'b1;
            if (&r_i) w_next = DONE;
        end else begin
            done   = 1'b1;
            w_next = IDLE;
        end
        if (clear) begin
            w_next = IDLE;
            done   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_WORDS; k++) begin
                r_dense[k] <= '0;
                r_acc[k]   <= '0;
            end
            r_i    <= '0;
            r_high <= '0;
            r_low  <= '0;
        end else begin
            if (clear) begin
                for (int k = 0; k < N_WORDS; k++)
                    r_acc[k] <= '0;
                r_i <= '0;
            end else if (r_state == RUN) begin
                r_acc[r_i] <= xor_result;
                r_i        <= r_i + 1'b1;
            end
            if (r_state == IDLE && load_valid)
                r_dense[load_addr] <= load_data;
            if (w_accept) begin
                r_high <= pos_high;
                r_low  <= pos_low;
            end
        end
    end
endmodule

// File: tb/tb_sparse_acc_sequencer.sv
// tb_sparse_acc_sequencer: models xor_adder around the DUT and scoreboards each pass
// against a bit-level cyclic rotation model of the accumulator.
module tb_sparse_acc_sequencer;
    localparam int LW = 3;
    localparam int NW = 8;
    localparam int PW = 8;

    logic          clk = 0, rst_n = 0, clear = 0, load_valid = 0, pos_valid = 0;
    logic [LW-1:0] load_addr = '0, rd_addr = '0;
    logic [31:0]   load_data = '0;
    logic [PW-1:0] pos_high = '0, pos_low = '0;
    logic          pos_ready, busy, done;
    logic [31:0]   high_left, high_right, low_left, low_right, acc_word, xor_result, rd_data;
    logic [4:0]    high_start, low_start;

    logic [31:0]   m_dense [NW];
    logic [255:0]  m_acc;
    logic [255:0]  q_exp [$];
    int            n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    // reference xor_adder: acc ^ window(high) ^ window(low)
    assign xor_result = acc_word ^ 32'({high_left, high_right} >> high_start)
                                 ^ 32'({low_left, low_right} >> low_start);

    sparse_acc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .pos_valid(pos_valid), .pos_ready(pos_ready), .pos_high(pos_high), .pos_low(pos_low),
        .high_left(high_left), .high_right(high_right), .low_left(low_left), .low_right(low_right),
        .acc_word(acc_word), .high_start(high_start), .low_start(low_start),
        .xor_result(xor_result), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rot(logic [255:0] d, int p);
        return p == 0 ? d : (d << p) | (d >> (256 - p));
    endfunction

    function automatic logic [255:0] dense_vec();
        logic [255:0] v;
        for (int k = 0; k < NW; k++) v[32*k +: 32] = m_dense[k];
        return v;
    endfunction

    task automatic load(int a, logic [31:0] d);
        @(negedge clk);
        load_valid = 1;
        load_addr  = LW'(a);
        load_data  = d;
        m_dense[a] = d;
        @(negedge clk);
        load_valid = 0;
    endtask

    task automatic offer(int h, int l);
        int c = 0;
        @(negedge clk);
        while (!pos_ready && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("ready_wait", pos_ready, 1);
        pos_valid = 1;
        pos_high  = PW'(h);
        pos_low   = PW'(l);
        @(negedge clk);
        pos_valid = 0;
    endtask

    task automatic check_acc(string tag, logic [255:0] e);
        for (int k = 0; k < NW; k++) begin
            rd_addr = LW'(k);
            #1;
            chk($sformatf("%s_acc%0d", tag, k), rd_data, e[32*k +: 32]);
        end
    endtask

    task automatic pass(string tag, int h, int l);
        int cyc = 1;
        m_acc ^= rot(dense_vec(), h) ^ rot(dense_vec(), l);
        q_exp.push_back(m_acc);
        offer(h, l);
        chk({tag, "_busy"}, busy, 1);
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, cyc, NW + 1);
        @(negedge clk);
        chk({tag, "_ready"}, {done, pos_ready}, 2'b01);
        check_acc(tag, q_exp.pop_front());
    endtask

    task automatic check_zero_outputs(string tag);
        chk({tag, "_ready"}, pos_ready, 1);
        chk({tag, "_busy_done"}, {busy, done}, 0);
        chk({tag, "_high"}, high_left | high_right, 0);
        chk({tag, "_low"}, low_left | low_right, 0);
        chk({tag, "_acc_rd"}, acc_word | rd_data, 0);
        chk({tag, "_start"}, {high_start, low_start}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen;
        for (int k = 0; k < NW; k++) m_dense[k] = '0;
        m_acc = '0;
        #3;
        check_zero_outputs("rst");
        repeat (2) @(negedge clk);
        rst_n = 1;

        load(0, 32'h0000_0001);
        pass("p1", 1, 40);
        check_acc("p1_const", {{6{32'h0}}, 32'h0000_0100, 32'h0000_0002});
        pass("p2", 1, 40);
        pass("same", 5, 5);

        // clear and load in the same IDLE cycle: both take effect
        @(negedge clk);
        clear = 1; load_valid = 1; load_addr = 0; load_data = 32'h0;
        m_dense[0] = 0;
        m_acc = '0;
        @(negedge clk);
        clear = 0; load_valid = 0;
        load(7, 32'h8000_0000);
        pass("wrap", 1, 0);
        check_acc("wrap_const", {32'h8000_0000, {6{32'h0}}, 32'h0000_0001});

        for (int r = 0; r < 4; r++) begin
            load($urandom_range(0, 7), $urandom);
            pass($sformatf("rnd%0d", r), $urandom_range(0, 255), $urandom_range(0, 255));
        end
        pass("edge", 255, 32);

        // load ignored in RUN, clear at RUN cycle 3 aborts the pass
        offer(3, 77);
        @(negedge clk);
        load_valid = 1; load_addr = 2; load_data = 32'hdead_beef;
        @(negedge clk);
        load_valid = 0;
        clear = 1;
        @(negedge clk);
        clear = 0;
        m_acc = '0;
        chk("clr_ready", pos_ready, 1);
        chk("clr_busy", busy, 0);
        check_acc("clr", m_acc);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("clr_nodone", seen, 0);
        pass("post_clr", 9, 200);

        // asynchronous reset mid-RUN
        offer(11, 100);
        repeat (3) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check_zero_outputs("mid_rst");
        for (int k = 0; k < NW; k++) m_dense[k] = '0;
        m_acc = '0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rel_ready", pos_ready, 1);
        chk("rel_done", done, 0);
        check_acc("rel", m_acc);
        load(4, $urandom);
        pass("post_rst", 130, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
